// File: rtl/ctrl_decode_irq_pipe.sv
// ctrl_decode_irq_pipe: MIPS ID-stage decode with a maskable, prioritised interrupt controller
// and an ID/EX control register that supports stall and flush.
module ctrl_decode_irq_pipe #(
    parameter int N_IRQ = 4,
    parameter int IRQ_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             id_valid,
    input  logic             kernel,
    input  logic             stall,
    input  logic             flush,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic [2:0]       pcsrc,
    output logic             irq_taken,
    output logic             exc_taken,
    output logic [IRQ_W-1:0] irq_id,
    output logic [N_IRQ-1:0] irq_pending,
    output logic             in_service,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_alusrc1,
    output logic             ex_alusrc2,
    output logic             ex_sign,
    output logic             ex_branch,
    output logic             ex_luop,
    output logic             ex_extop,
    output logic [1:0]       ex_regdst,
    output logic [1:0]       ex_memtoreg,
    output logic [5:0]       ex_alufun
);
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc1;
        logic       alusrc2;
        logic       sign;
        logic       branch;
        logic       luop;
        logic       extop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [5:0] alufun;
    } ctrl_t;

    // Trap entries write the return address into $k0.
    localparam ctrl_t C_IRQ = ctrl_t'({9'b100000000, 2'b11, 2'b11, 6'b000000});
    localparam ctrl_t C_EXC = ctrl_t'({9'b100000000, 2'b11, 2'b10, 6'b000000});

    logic [N_IRQ-1:0] r_s1, r_s2, r_s3, r_pend;
    logic [N_IRQ-1:0] w_act, w_clr;
    logic [IRQ_W-1:0] r_id, w_win;
    logic             r_ins;
    ctrl_t            r_ex, w_dec, w_nxt;
    logic             w_rtype, w_jr, w_jalr, w_jump, w_legal;
    logic             w_take_irq, w_take_exc, w_live;
    logic [5:0]       w_rfun, w_ifun;

    assign w_rtype = opcode == 6'h00;
    assign w_jr    = w_rtype & (funct == 6'h08);
    assign w_jalr  = w_rtype & (funct == 6'h09);
    assign w_jump  = (opcode == 6'h02) | (opcode == 6'h03);
    assign w_legal = (opcode <= 6'h0c) | (opcode == 6'h0f) | (opcode == 6'h23) | (opcode == 6'h2b);
    assign w_live  = id_valid & ~kernel & ~stall;

    assign w_act = r_pend & irq_mask;

    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (w_act[i]) w_win = IRQ_W'(i);
    end

    assign w_take_irq = w_live & ~r_ins & (|w_act);
    assign w_take_exc = w_live & ~w_legal & ~w_take_irq;
    assign w_clr      = w_take_irq ? (N_IRQ'(1) << w_win) : '0;

    always_comb begin
        w_rfun = 6'b000000;
        case (funct)
            6'h22, 6'h23: w_rfun = 6'b000001;
            6'h24:        w_rfun = 6'b011000;
            6'h25:        w_rfun = 6'b011110;
            6'h26:        w_rfun = 6'b010110;
            6'h27:        w_rfun = 6'b010001;
            6'h00:        w_rfun = 6'b100000;
            6'h02:        w_rfun = 6'b100001;
            6'h03:        w_rfun = 6'b100011;
            6'h2a, 6'h2b: w_rfun = 6'b000011;
            default:      w_rfun = 6'b000000;
        endcase
    end

    always_comb begin
        w_ifun = 6'b000000;
        case (opcode)
            6'h0a, 6'h0b: w_ifun = 6'b000011;
            6'h0c:        w_ifun = 6'b011000;
            6'h04:        w_ifun = 6'b110011;
            6'h05:        w_ifun = 6'b110001;
            6'h06:        w_ifun = 6'b111101;
            6'h07:        w_ifun = 6'b111111;
            6'h01:        w_ifun = 6'b111011;
            default:      w_ifun = 6'b000000;
        endcase
    end

    always_comb begin
        w_dec          = '0;
        w_dec.regwrite = w_rtype ? ~w_jr : (opcode inside {6'h03, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23});
        w_dec.memread  = opcode == 6'h23;
        w_dec.memwrite = opcode == 6'h2b;
        w_dec.alusrc1  = w_rtype & (funct inside {6'h00, 6'h02, 6'h03});
        w_dec.alusrc2  = opcode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
        w_dec.sign     = ~((w_rtype & (funct == 6'h2b)) | (opcode == 6'h0b));
        w_dec.branch   = opcode inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
        w_dec.luop     = opcode == 6'h0f;
        w_dec.extop    = opcode != 6'h0c;
        w_dec.regdst   = w_rtype ? 2'b01 : (opcode == 6'h03) ? 2'b10 : 2'b00;
        w_dec.memtoreg = (opcode == 6'h23) ? 2'b01 : ((opcode == 6'h03) | w_jalr) ? 2'b10 : 2'b00;
        w_dec.alufun   = w_rtype ? w_rfun : w_ifun;
    end

    // Illegal opcodes that do not trap (kernel mode) become bubbles.
    assign w_nxt = ~id_valid ? '0 : w_take_irq ? C_IRQ : w_take_exc ? C_EXC : ~w_legal ? '0 : w_dec;

    assign pcsrc = w_take_irq ? 3'b100 :
                   w_take_exc ? 3'b101 :
                   ~(id_valid & ~stall & w_legal) ? 3'b000 :
                   w_jump ? 3'b010 :
                   (w_jr | w_jalr) ? 3'b011 : 3'b000;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_pend <= '0;
            r_id   <= '0;
            r_ins  <= 1'b0;
            r_ex   <= '0;
        end else begin
            r_s1   <= irq;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_pend <= (r_pend | (r_s2 & ~r_s3)) & ~w_clr;
            if (w_take_irq)
                r_id <= w_win;
            if (w_take_irq)
                r_ins <= 1'b1;
            else if (id_valid & kernel & ~stall & w_jr)
                r_ins <= 1'b0;
            if (flush)
                r_ex <= '0;
            else if (!stall)
                r_ex <= w_nxt;
        end
    end

    assign irq_taken   = w_take_irq;
    assign exc_taken   = w_take_exc;
    assign irq_id      = r_id;
    assign irq_pending = r_pend;
    assign in_service  = r_ins;
    assign ex_regwrite = r_ex.regwrite;
    assign ex_memread  = r_ex.memread;
    assign ex_memwrite = r_ex.memwrite;
    assign ex_alusrc1  = r_ex.alusrc1;
    assign ex_alusrc2  = r_ex.alusrc2;
    assign ex_sign     = r_ex.sign;
    assign ex_branch   = r_ex.branch;
    assign ex_luop     = r_ex.luop;
    assign ex_extop    = r_ex.extop;
    assign ex_regdst   = r_ex.regdst;
    assign ex_memtoreg = r_ex.memtoreg;
    assign ex_alufun   = r_ex.alufun;
endmodule

// File: tb/tb_ctrl_decode_irq_pipe.sv
// tb_ctrl_decode_irq_pipe: scoreboard bench for decode, interrupt/exception entry and ID/EX stall/flush.
module tb_ctrl_decode_irq_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       id_valid, kernel, stall, flush;
    logic [3:0] irq, irq_mask;
    logic [2:0] pcsrc;
    logic       irq_taken, exc_taken, in_service;
    logic [1:0] irq_id;
    logic [3:0] irq_pending;
    logic       ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1, ex_alusrc2;
    logic       ex_sign, ex_branch, ex_luop, ex_extop;
    logic [1:0] ex_regdst, ex_memtoreg;
    logic [5:0] ex_alufun;

    int n_cmp = 0;
    int n_err = 0;
    logic [18:0] exp_q[$];
    logic [18:0] last_ex = '0;
    logic [18:0] w_ex;

    // {regwrite,memread,memwrite,alusrc1,alusrc2,sign,branch,luop,extop}, regdst, memtoreg, alufun
    localparam logic [18:0] E_ADD   = {9'b100001001, 2'b01, 2'b00, 6'b000000};
    localparam logic [18:0] E_SUB   = {9'b100001001, 2'b01, 2'b00, 6'b000001};
    localparam logic [18:0] E_SLL   = {9'b100101001, 2'b01, 2'b00, 6'b100000};
    localparam logic [18:0] E_SLTU  = {9'b100000001, 2'b01, 2'b00, 6'b000011};
    localparam logic [18:0] E_LW    = {9'b110011001, 2'b00, 2'b01, 6'b000000};
    localparam logic [18:0] E_SW    = {9'b001011001, 2'b00, 2'b00, 6'b000000};
    localparam logic [18:0] E_BEQ   = {9'b000001101, 2'b00, 2'b00, 6'b110011};
    localparam logic [18:0] E_ANDI  = {9'b100011000, 2'b00, 2'b00, 6'b011000};
    localparam logic [18:0] E_LUI   = {9'b100011011, 2'b00, 2'b00, 6'b000000};
    localparam logic [18:0] E_SLTIU = {9'b100010001, 2'b00, 2'b00, 6'b000011};
    localparam logic [18:0] E_J     = {9'b000001001, 2'b00, 2'b00, 6'b000000};
    localparam logic [18:0] E_JAL   = {9'b100001001, 2'b10, 2'b10, 6'b000000};
    localparam logic [18:0] E_JR    = {9'b000001001, 2'b01, 2'b00, 6'b000000};
    localparam logic [18:0] E_IRQ   = {9'b100000000, 2'b11, 2'b11, 6'b000000};
    localparam logic [18:0] E_EXC   = {9'b100000000, 2'b11, 2'b10, 6'b000000};
    localparam logic [18:0] E_NOP   = '0;

    assign w_ex = {ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1, ex_alusrc2, ex_sign,
                   ex_branch, ex_luop, ex_extop, ex_regdst, ex_memtoreg, ex_alufun};

    ctrl_decode_irq_pipe dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .id_valid(id_valid),
        .kernel(kernel), .stall(stall), .flush(flush), .irq(irq), .irq_mask(irq_mask),
        .pcsrc(pcsrc), .irq_taken(irq_taken), .exc_taken(exc_taken), .irq_id(irq_id),
        .irq_pending(irq_pending), .in_service(in_service),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_sign(ex_sign),
        .ex_branch(ex_branch), .ex_luop(ex_luop), .ex_extop(ex_extop),
        .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg), .ex_alufun(ex_alufun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One ID cycle: drive, check combinational outputs, then check the ID/EX register after the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic v, input logic k, input logic st, input logic fl,
                        input logic [2:0] e_pc, input logic e_it, input logic e_et,
                        input logic [18:0] e_ld);
        logic [18:0] e;
        @(negedge clk);
        opcode = op; funct = fn; id_valid = v; kernel = k; stall = st; flush = fl;
        #1;
        chk({tag, ".pcsrc"}, 32'(pcsrc), 32'(e_pc));
        chk({tag, ".irq_taken"}, 32'(irq_taken), 32'(e_it));
        chk({tag, ".exc_taken"}, 32'(exc_taken), 32'(e_et));
        exp_q.push_back(fl ? E_NOP : st ? last_ex : e_ld);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".idex"}, 32'(w_ex), 32'(e));
        last_ex = e;
    endtask

    task automatic bubble(input string tag);
        step(tag, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, E_NOP);
    endtask

    task automatic user_add(input string tag, input logic [2:0] e_pc, input logic e_it, input logic [18:0] e_ld);
        step(tag, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 1'b0, e_pc, e_it, 1'b0, e_ld);
    endtask

    task automatic kernel_jr(input string tag);
        step(tag, 6'h00, 6'h08, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, E_JR);
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; id_valid = 1'b0; kernel = 1'b0;
        stall = 1'b0; flush = 1'b0; irq = '0; irq_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.idex", 32'(w_ex), 32'(E_NOP));
        chk("rst.pending", 32'(irq_pending), 32'h0);
        chk("rst.in_service", 32'(in_service), 32'h0);
        chk("rst.irq_id", 32'(irq_id), 32'h0);
        chk("rst.pcsrc", 32'(pcsrc), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        user_add("add", 3'b000, 1'b0, E_ADD);
        step("sub",   6'h00, 6'h22, 1, 0, 0, 0, 3'b000, 0, 0, E_SUB);
        step("sll",   6'h00, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_SLL);
        step("sltu",  6'h00, 6'h2b, 1, 0, 0, 0, 3'b000, 0, 0, E_SLTU);
        step("lw",    6'h23, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_LW);
        step("sw",    6'h2b, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_SW);
        step("beq",   6'h04, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_BEQ);
        step("andi",  6'h0c, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_ANDI);
        step("lui",   6'h0f, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_LUI);
        step("sltiu", 6'h0b, 6'h00, 1, 0, 0, 0, 3'b000, 0, 0, E_SLTIU);
        step("j",     6'h02, 6'h00, 1, 0, 0, 0, 3'b010, 0, 0, E_J);
        step("jal",   6'h03, 6'h00, 1, 0, 0, 0, 3'b010, 0, 0, E_JAL);
        step("jr",    6'h00, 6'h08, 1, 0, 0, 0, 3'b011, 0, 0, E_JR);
        step("nop_j", 6'h02, 6'h00, 0, 0, 0, 0, 3'b000, 0, 0, E_NOP);

        irq_mask = 4'hf;
        irq = 4'b0011;
        bubble("sync1");
        bubble("sync2");
        chk("pend.2clk", 32'(irq_pending), 32'h0);
        bubble("sync3");
        chk("pend.3clk", 32'(irq_pending), 32'h3);
        user_add("take0", 3'b100, 1'b1, E_IRQ);
        chk("take0.irq_id", 32'(irq_id), 32'h0);
        chk("take0.pending", 32'(irq_pending), 32'h2);
        chk("take0.in_service", 32'(in_service), 32'h1);
        user_add("insvc", 3'b000, 1'b0, E_ADD);
        chk("insvc.pending", 32'(irq_pending), 32'h2);
        kernel_jr("ret0");
        chk("ret0.in_service", 32'(in_service), 32'h0);
        user_add("take1", 3'b100, 1'b1, E_IRQ);
        chk("take1.irq_id", 32'(irq_id), 32'h1);
        chk("take1.pending", 32'(irq_pending), 32'h0);
        kernel_jr("ret1");
        irq = 4'b0000;

        step("exc_user", 6'h3f, 6'h00, 1, 0, 0, 0, 3'b101, 0, 1, E_EXC);
        step("exc_kern", 6'h3f, 6'h00, 1, 1, 0, 0, 3'b000, 0, 0, E_NOP);
        step("exc_stall", 6'h3f, 6'h00, 1, 0, 1, 0, 3'b000, 0, 0, E_NOP);

        irq_mask = 4'b0101;
        irq = 4'b1010;
        bubble("msync1");
        bubble("msync2");
        bubble("msync3");
        chk("mask.pending", 32'(irq_pending), 32'ha);
        user_add("masked", 3'b000, 1'b0, E_ADD);
        chk("masked.pending", 32'(irq_pending), 32'ha);
        irq_mask = 4'hf;
        user_add("unmask", 3'b100, 1'b1, E_IRQ);
        chk("unmask.irq_id", 32'(irq_id), 32'h1);
        chk("unmask.pending", 32'(irq_pending), 32'h8);
        kernel_jr("ret2");

        step("stall_sw", 6'h2b, 6'h00, 1, 0, 1, 0, 3'b000, 0, 0, E_SW);
        chk("stall.pending", 32'(irq_pending), 32'h8);
        step("stall_flush", 6'h2b, 6'h00, 1, 0, 1, 1, 3'b000, 0, 0, E_SW);
        user_add("take3", 3'b100, 1'b1, E_IRQ);
        chk("take3.irq_id", 32'(irq_id), 32'h3);

        irq = 4'b1110;
        user_add("h1", 3'b000, 1'b0, E_ADD);
        user_add("h2", 3'b000, 1'b0, E_ADD);
        user_add("h3", 3'b000, 1'b0, E_ADD);
        chk("mid.pending", 32'(irq_pending), 32'h4);
        chk("mid.in_service", 32'(in_service), 32'h1);

        @(negedge clk);
        reset = 1'b0; opcode = 6'h00; funct = 6'h20; id_valid = 1'b1; kernel = 1'b0;
        stall = 1'b0; flush = 1'b0;
        exp_q.push_back(E_NOP);
        @(posedge clk);
        #1;
        chk("mrst.idex", 32'(w_ex), 32'(exp_q.pop_front()));
        chk("mrst.pending", 32'(irq_pending), 32'h0);
        chk("mrst.in_service", 32'(in_service), 32'h0);
        chk("mrst.irq_id", 32'(irq_id), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
